memory_bus: RTL and testbench

- Successor to the single-cycle memory map decoder, for the hart's load/store unit.
- Accepts one request at a time over a valid/ready handshake and decodes it to ROM, internal RAM, input peripherals or output peripherals.
- Adds parametrised region sizes, byte/halfword/word access on every region, and automatic splitting of misaligned accesses that cross a word boundary.
- Flags access faults instead of returning X.

---
 rtl/memory_bus.sv | 206 ++++++++++++++++++++
 tb/tb_memory_bus.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus.sv
// Load/store memory bus: decodes one request at a time to ROM, internal RAM, input or output
// peripherals, splitting misaligned accesses that cross a word boundary into two word accesses.
module memory_bus #(
  parameter int unsigned XLEN                = 32,
  parameter int unsigned ROM_BYTES           = 2048,
  parameter int unsigned RAM_BYTES           = 1024,
  parameter logic [31:0] RAM_START           = 32'h0800,
  parameter logic [31:0] INPUT_PERIPH_START  = 32'h1000,
  parameter int unsigned INPUT_PERIPH_LEN    = 16,
  parameter logic [31:0] OUTPUT_PERIPH_START = 32'h1800,
  parameter int unsigned OUTPUT_PERIPH_LEN   = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_wenable,
  input  logic [1:0]      req_width,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-3:0] rom_addr,
  input  logic [XLEN-1:0] rom_rdata,
  input  logic [7:0]      input_peripherals_mem [INPUT_PERIPH_LEN],
  output logic [7:0]      output_peripherals_mem [OUTPUT_PERIPH_LEN],
  output logic [2:0]      dbg_state
);

  localparam int RAM_WORDS = RAM_BYTES / 4;
  localparam int RAM_AW    = $clog2(RAM_WORDS);

  // Handshake: a request transfers on a posedge where req_valid && req_ready; req_ready is high only
  // in IDLE, and the response is a single resp_valid cycle with no backpressure.
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_ACC0 = 3'd1, S_ACC1 = 3'd2, S_RESP = 3'd3, S_FAULT = 3'd4} state_t;
  typedef enum logic [2:0] {RG_NONE, RG_ROM, RG_RAM, RG_IN, RG_OUT} region_t;

  function automatic region_t region_of(input logic [XLEN-1:0] a);
    region_t rg;
    rg = RG_NONE;
    if (a < XLEN'(ROM_BYTES))                                   rg = RG_ROM;
    else if ((a - RAM_START) < XLEN'(RAM_BYTES))                rg = RG_RAM;
    else if ((a - INPUT_PERIPH_START) < XLEN'(INPUT_PERIPH_LEN))   rg = RG_IN;
    else if ((a - OUTPUT_PERIPH_START) < XLEN'(OUTPUT_PERIPH_LEN)) rg = RG_OUT;
    return rg;
  endfunction

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_addr;
  logic            r_wen;
  logic [1:0]      r_width;
  logic [7:0]      r_mask;
  logic [63:0]     r_wdata;
  region_t         r_region;
  logic            r_cross;
  logic [63:0]     r_rd;
  logic [7:0]      r_ram [4][RAM_WORDS];
  logic [7:0]      r_out [OUTPUT_PERIPH_LEN];

  logic [1:0]      w_span;
  logic [3:0]      w_base;
  logic [XLEN-1:0] w_last;
  region_t         w_rg_first, w_rg_last;
  logic            w_fault, w_cross, w_accept;
  logic [7:0]      w_mask;
  logic [63:0]     w_wdata64;

  always_comb begin
    w_span = 2'd3;
    w_base = 4'b1111;
    case (req_width)
      2'b00:   begin w_span = 2'd0; w_base = 4'b0001; end
      2'b01:   begin w_span = 2'd1; w_base = 4'b0011; end
      default: begin w_span = 2'd3; w_base = 4'b1111; end
    endcase
  end

  // Decode looks at both ends so an access straddling two regions, or running off one, faults.
  assign w_last     = req_addr + XLEN'(w_span);
  assign w_rg_first = region_of(req_addr);
  assign w_rg_last  = region_of(w_last);
  assign w_fault    = (req_width == 2'b11) || (w_rg_first == RG_NONE) || (w_rg_first != w_rg_last) ||
                      (req_wenable && (w_rg_first == RG_ROM || w_rg_first == RG_IN)) ||
                      (!req_wenable && (w_rg_first == RG_OUT));
  assign w_cross    = ({1'b0, req_addr[1:0]} + {1'b0, w_span}) > 3'd3;
  assign w_mask     = {4'b0000, w_base} << req_addr[1:0];
  assign w_wdata64  = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
  assign w_accept   = req_valid && req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_fault ? S_FAULT : S_ACC0;
      S_ACC0:  w_next = r_cross ? S_ACC1 : S_RESP;
      S_ACC1:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  logic            w_acc, w_hi;
  logic [XLEN-1:0] w_word_addr, w_ram_off, w_in_off, w_out_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [3:0]      w_lane_en;
  logic [31:0]     w_lane_wd, w_in_word, w_ram_word, w_rd_word;

  assign w_acc       = (r_state == S_ACC0) || (r_state == S_ACC1);
  assign w_hi        = (r_state == S_ACC1);
  assign w_word_addr = {r_addr[XLEN-1:2] + (XLEN-2)'(w_hi), 2'b00};
  assign rom_addr    = w_word_addr[XLEN-1:2];
  assign w_lane_en   = w_hi ? r_mask[7:4] : r_mask[3:0];
  assign w_lane_wd   = w_hi ? r_wdata[63:32] : r_wdata[31:0];
  assign w_ram_off   = w_word_addr - RAM_START;
  assign w_ram_idx   = w_ram_off[RAM_AW+1:2];
  assign w_in_off    = w_word_addr - INPUT_PERIPH_START;
  assign w_out_off   = w_word_addr - OUTPUT_PERIPH_START;
  assign w_ram_word  = {r_ram[3][w_ram_idx], r_ram[2][w_ram_idx], r_ram[1][w_ram_idx], r_ram[0][w_ram_idx]};

  always_comb begin
    w_in_word = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < INPUT_PERIPH_LEN; j++)
        if (w_in_off + XLEN'(k) == XLEN'(j)) w_in_word[8*k +: 8] = input_peripherals_mem[j];
  end

  always_comb begin
    case (r_region)
      RG_ROM:  w_rd_word = rom_rdata;
      RG_RAM:  w_rd_word = w_ram_word;
      RG_IN:   w_rd_word = w_in_word;
      default: w_rd_word = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_wen    <= 1'b0;
      r_width  <= 2'b00;
      r_mask   <= '0;
      r_wdata  <= '0;
      r_region <= RG_NONE;
      r_cross  <= 1'b0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_wen    <= req_wenable;
      r_width  <= req_width;
      r_mask   <= w_mask;
      r_wdata  <= w_wdata64;
      r_region <= w_rg_first;
      r_cross  <= w_cross;
      r_rd     <= '0;
    end else if (w_acc && !r_wen) begin
      if (w_hi) r_rd[63:32] <= w_rd_word;
      else      r_rd[31:0]  <= w_rd_word;
    end
  end

  // RAM contents survive reset; an aborted access never reaches here because reset forces IDLE.
  always_ff @(posedge clock) begin
    if (w_acc && r_wen && r_region == RG_RAM)
      for (int k = 0; k < 4; k++)
        if (w_lane_en[k]) r_ram[k][w_ram_idx] <= w_lane_wd[8*k +: 8];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < OUTPUT_PERIPH_LEN; j++) r_out[j] <= '0;
    end else if (w_acc && r_wen && r_region == RG_OUT) begin
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < OUTPUT_PERIPH_LEN; j++)
          if (w_lane_en[k] && (w_out_off + XLEN'(k) == XLEN'(j))) r_out[j] <= w_lane_wd[8*k +: 8];
    end
  end

  assign output_peripherals_mem = r_out;

  logic [63:0] w_rd_shift;
  logic [31:0] w_rd_res;
  logic        w_unused;

  assign w_rd_shift = r_rd >> {r_addr[1:0], 3'b000};
  always_comb begin
    case (r_width)
      2'b00:   w_rd_res = {24'b0, w_rd_shift[7:0]};
      2'b01:   w_rd_res = {16'b0, w_rd_shift[15:0]};
      default: w_rd_res = w_rd_shift[31:0];
    endcase
  end

  assign w_unused   = ^{w_rd_shift[63:32], w_ram_off[XLEN-1:RAM_AW+2], w_ram_off[1:0]};
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP) || (r_state == S_FAULT);
  assign resp_fault = (r_state == S_FAULT);
  assign resp_rdata = (r_state == S_RESP && !r_wen) ? w_rd_res : '0;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_memory_bus.sv
// Directed bench for memory_bus: RAM, ROM and peripheral accesses, crossing splits, faults,
// back-to-back handshakes and reset aborting a split write.
module tb_memory_bus;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wenable = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [29:0] rom_addr;
  logic [31:0] rom_rdata;
  logic [7:0]  in_mem  [16];
  logic [7:0]  out_mem [16];
  logic [2:0]  dbg_state;
  logic [31:0] rom_mem [512];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat;
  logic [31:0] rd;
  logic        flt;
  logic [31:0] exp_q [$];

  memory_bus dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wenable(req_wenable), .req_width(req_width), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .input_peripherals_mem(in_mem), .output_peripherals_mem(out_mem), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // ROM word presented for the address driven in the current cycle, read at that cycle's end.
  assign rom_rdata = rom_mem[rom_addr[8:0]];

  initial begin
    for (int i = 0; i < 512; i++) rom_mem[i] = 32'hC0DE0000 | i;
    for (int i = 0; i < 16; i++) in_mem[i] = 8'h10 + 8'(i);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Issue one request; lat counts negedges from acceptance to response (-1 on timeout).
  task automatic do_req(input logic wen, input logic [1:0] width, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_wenable = wen; req_width = width; req_addr = addr; req_wdata = wdata;
    lat = -1; rd = '0; flt = 1'b0;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clock); n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_wenable = 1'($urandom_range(0, 1)); req_width = 2'($urandom_range(0, 3));
    n = 1;
    while (!resp_valid && n < 10) begin @(negedge clock); n++; end
    if (resp_valid) begin lat = n; rd = resp_rdata; flt = resp_fault; end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", resp_valid); end
    n_cmp++; if (resp_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b exp 0", resp_fault); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", resp_rdata); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (out_mem[i] !== 8'h00) begin n_fail++; $display("FAIL rst_out[%0d]: got %h exp 00", i, out_mem[i]); end
    end
  endtask

  task automatic test_ram_word();
    do_req(1'b1, 2'b10, 32'h0800, 32'hDEADBEEF);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL ram_wr_lat: got %0d exp 2", lat); end
    n_cmp++; if (flt !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL ram_wr_resp: got f=%b d=%h exp f=0 d=0", flt, rd); end
    do_req(1'b0, 2'b10, 32'h0800, 32'h0);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL ram_rd_lat: got %0d exp 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rd_data: got %h exp deadbeef", rd); end
    n_cmp++; if (flt !== 1'b0) begin n_fail++; $display("FAIL ram_rd_fault: got %b exp 0", flt); end
    do_req(1'b1, 2'b10, 32'h0804, 32'h11223344);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL ram_wr2_lat: got %0d exp 2", lat); end
  endtask

  task automatic test_crossing();
    do_req(1'b1, 2'b01, 32'h0803, 32'h0000A55A);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL cross_wr_lat: got %0d exp 3", lat); end
    n_cmp++; if (flt !== 1'b0) begin n_fail++; $display("FAIL cross_wr_fault: got %b exp 0", flt); end
    do_req(1'b0, 2'b10, 32'h0800, 32'h0);
    n_cmp++; if (rd !== 32'h5AADBEEF) begin n_fail++; $display("FAIL cross_w0: got %h exp 5aadbeef", rd); end
    do_req(1'b0, 2'b10, 32'h0804, 32'h0);
    n_cmp++; if (rd !== 32'h112233A5) begin n_fail++; $display("FAIL cross_w1: got %h exp 112233a5", rd); end
    do_req(1'b0, 2'b01, 32'h0803, 32'h0);
    n_cmp++; if (lat !== 3 || rd !== 32'h0000A55A) begin n_fail++; $display("FAIL cross_rd_half: got lat=%0d d=%h exp lat=3 d=a55a", lat, rd); end
    do_req(1'b0, 2'b10, 32'h0802, 32'h0);
    n_cmp++; if (lat !== 3 || rd !== 32'h33A55AAD) begin n_fail++; $display("FAIL cross_rd_word: got lat=%0d d=%h exp lat=3 d=33a55aad", lat, rd); end
    do_req(1'b0, 2'b00, 32'h0802, 32'h0);
    n_cmp++; if (lat !== 2 || rd !== 32'h000000AD) begin n_fail++; $display("FAIL rd_byte: got lat=%0d d=%h exp lat=2 d=ad", lat, rd); end
    do_req(1'b0, 2'b01, 32'h0801, 32'h0);
    n_cmp++; if (lat !== 2 || rd !== 32'h0000ADBE) begin n_fail++; $display("FAIL rd_half_mis: got lat=%0d d=%h exp lat=2 d=adbe", lat, rd); end
  endtask

  task automatic test_rom();
    do_req(1'b0, 2'b10, 32'h0004, 32'h0);
    n_cmp++; if (lat !== 2 || rd !== 32'hC0DE0001) begin n_fail++; $display("FAIL rom_word: got lat=%0d d=%h exp lat=2 d=c0de0001", lat, rd); end
    do_req(1'b0, 2'b10, 32'h0007, 32'h0);
    n_cmp++; if (lat !== 3 || rd !== 32'hDE0002C0) begin n_fail++; $display("FAIL rom_cross: got lat=%0d d=%h exp lat=3 d=de0002c0", lat, rd); end
    do_req(1'b0, 2'b00, 32'h07FF, 32'h0);
    n_cmp++; if (flt !== 1'b0 || rd !== 32'h000000C0) begin n_fail++; $display("FAIL rom_last_byte: got f=%b d=%h exp f=0 d=c0", flt, rd); end
  endtask

  task automatic test_input();
    do_req(1'b0, 2'b00, 32'h1005, 32'h0);
    n_cmp++; if (lat !== 2 || rd !== 32'h00000015) begin n_fail++; $display("FAIL in_byte: got lat=%0d d=%h exp lat=2 d=15", lat, rd); end
    do_req(1'b0, 2'b10, 32'h1004, 32'h0);
    n_cmp++; if (rd !== 32'h17161514) begin n_fail++; $display("FAIL in_word: got %h exp 17161514", rd); end
    do_req(1'b0, 2'b01, 32'h1007, 32'h0);
    n_cmp++; if (lat !== 3 || rd !== 32'h00001817) begin n_fail++; $display("FAIL in_cross: got lat=%0d d=%h exp lat=3 d=1817", lat, rd); end
  endtask

  task automatic test_output();
    do_req(1'b1, 2'b00, 32'h1802, 32'h0000007E);
    n_cmp++; if (lat !== 2 || flt !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL out_wr_resp: got lat=%0d f=%b d=%h exp 2/0/0", lat, flt, rd); end
    n_cmp++; if (out_mem[2] !== 8'h7E) begin n_fail++; $display("FAIL out_byte2: got %h exp 7e", out_mem[2]); end
    n_cmp++; if (out_mem[1] !== 8'h00 || out_mem[3] !== 8'h00) begin n_fail++; $display("FAIL out_neigh: got %h %h exp 00 00", out_mem[1], out_mem[3]); end
    do_req(1'b1, 2'b10, 32'h180C, 32'h44332211);
    n_cmp++; if (out_mem[12] !== 8'h11 || out_mem[15] !== 8'h44) begin n_fail++; $display("FAIL out_word: got %h %h exp 11 44", out_mem[12], out_mem[15]); end
    do_req(1'b1, 2'b01, 32'h1803, 32'h0000BBAA);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL out_cross_lat: got %0d exp 3", lat); end
    n_cmp++; if (out_mem[3] !== 8'hAA || out_mem[4] !== 8'hBB || out_mem[2] !== 8'h7E) begin
      n_fail++; $display("FAIL out_cross: got %h %h %h exp 7e aa bb", out_mem[2], out_mem[3], out_mem[4]); end
  endtask

  task automatic test_faults();
    logic        wens   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  widths [6] = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00};
    logic [31:0] addrs  [6] = '{32'h0000, 32'h1800, 32'h0800, 32'h0BFE, 32'h07FE, 32'h1000};
    for (int i = 0; i < 6; i++) begin
      do_req(wens[i], widths[i], addrs[i], 32'hFFFFFFFF);
      n_cmp++; if (lat !== 1 || flt !== 1'b1 || rd !== 32'h0) begin
        n_fail++; $display("FAIL fault_%0d: got lat=%0d f=%b d=%h exp lat=1 f=1 d=0", i, lat, flt, rd); end
    end
    do_req(1'b0, 2'b10, 32'h0800, 32'h0);
    n_cmp++; if (rd !== 32'h5AADBEEF) begin n_fail++; $display("FAIL fault_no_side_effect: got %h exp 5aadbeef", rd); end
    n_cmp++; if (out_mem[0] !== 8'h00) begin n_fail++; $display("FAIL fault_out0: got %h exp 00", out_mem[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h0800, 32'h0804, 32'h0800};
    logic [11:0] rdy_v, rsp_v;
    logic [31:0] e;
    int na;
    bit just;
    na = 0; just = 1'b0; rdy_v = '0; rsp_v = '0;
    @(negedge clock);
    req_valid = 1'b1; req_wenable = 1'b0; req_width = 2'b10; req_addr = addrs[0];
    for (int c = 0; c < 12; c++) begin
      rdy_v[c] = req_ready;
      rsp_v[c] = resp_valid;
      if (resp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        n_cmp++; if (resp_rdata !== e || resp_fault !== 1'b0) begin
          n_fail++; $display("FAIL b2b_data c%0d: got d=%h f=%b exp d=%h f=0", c, resp_rdata, resp_fault, e); end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back((req_addr == 32'h0800) ? 32'h5AADBEEF : 32'h112233A5);
        na++; just = 1'b1;
      end else if (just) begin
        just = 1'b0;
        if (na < 3) req_addr = addrs[na];
        else begin req_valid = 1'b0; req_addr = $urandom; end
      end
      @(negedge clock);
    end
    n_cmp++; if (rdy_v !== 12'hE49) begin n_fail++; $display("FAIL b2b_ready: got %b exp %b", rdy_v, 12'hE49); end
    n_cmp++; if (rsp_v !== 12'h124) begin n_fail++; $display("FAIL b2b_resp: got %b exp %b", rsp_v, 12'h124); end
    n_cmp++; if (na !== 3 || exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_count: got acc=%0d left=%0d exp 3 0", na, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit saw;
    do_req(1'b1, 2'b10, 32'h0808, 32'h01020304);
    do_req(1'b1, 2'b10, 32'h080C, 32'h05060708);
    @(negedge clock);
    req_valid = 1'b1; req_wenable = 1'b1; req_width = 2'b10; req_addr = 32'h080A; req_wdata = 32'h99887766;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (dbg_state !== 3'd2) begin n_fail++; $display("FAIL mid_in_acc1: got %0d exp 2", dbg_state); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL mid_ready: got r=%b s=%0d exp 1 0", req_ready, dbg_state); end
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) saw = 1'b1;
      @(negedge clock);
    end
    n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp: got %b exp 0", saw); end
    reset_n = 1'b1;
    n_cmp++; if (out_mem[2] !== 8'h00 || out_mem[12] !== 8'h00) begin n_fail++; $display("FAIL out_cleared: got %h %h exp 00 00", out_mem[2], out_mem[12]); end
    do_req(1'b0, 2'b10, 32'h0808, 32'h0);
    n_cmp++; if (rd !== 32'h77660304) begin n_fail++; $display("FAIL mid_word0: got %h exp 77660304", rd); end
    do_req(1'b0, 2'b10, 32'h080C, 32'h0);
    n_cmp++; if (rd !== 32'h05060708) begin n_fail++; $display("FAIL mid_word1: got %h exp 05060708", rd); end
    do_req(1'b0, 2'b10, 32'h0800, 32'h0);
    n_cmp++; if (rd !== 32'h5AADBEEF) begin n_fail++; $display("FAIL ram_kept: got %h exp 5aadbeef", rd); end
  endtask

  initial begin
    test_reset();
    test_ram_word();
    test_crossing();
    test_rom();
    test_input();
    test_output();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
